// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: expands one FIXED/INCR/WRAP command into a beat stream.
// Define AXI_4KB_CHECK_EN to reject INCR bursts whose last byte lands in another 4KB page.
module axi_burst_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic              cmd_op,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [ADDR_W-1:0] beat_addr,
    output logic [LEN_W-1:0]  beat_idx,
    output logic              beat_last,
    output logic              beat_op,
    output logic              err_valid,
    output logic [2:0]        err_code,
    output logic [CNT_W-1:0]  burst_cnt
);

    localparam logic [2:0] MAX_SIZE    = 3'($clog2(DATA_W / 8));
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_r;
    logic [2:0]        size_r;
    logic [1:0]        burst_r;
    logic [ADDR_W-1:0] wrap_lower;
    logic [ADDR_W-1:0] wrap_span;

    logic [2:0]        cmd_code;
    logic [ADDR_W-1:0] cmd_span;
    logic [LEN_W-1:0]  idx_next;
    logic [ADDR_W-1:0] addr_next;

    function automatic logic [ADDR_W-1:0] beat_bytes(input logic [2:0] size);
        return ADDR_W'(1) << size;
    endfunction

    // Total bytes covered by the burst; for WRAP this is the wrap window.
    function automatic logic [ADDR_W-1:0] span_bytes(input logic [LEN_W-1:0] len,
                                                     input logic [2:0] size);
        return (ADDR_W'(len) + ADDR_W'(1)) << size;
    endfunction

`ifdef AXI_4KB_CHECK_EN
    function automatic logic crosses_4kb(input logic [ADDR_W-1:0] addr,
                                         input logic [LEN_W-1:0]  len,
                                         input logic [2:0]        size);
        logic [ADDR_W-1:0] last_byte;
        last_byte = (addr & ~(beat_bytes(size) - ADDR_W'(1))) + span_bytes(len, size)
                    - ADDR_W'(1);
        return last_byte[ADDR_W-1:12] != addr[ADDR_W-1:12];
    endfunction
`endif

    function automatic logic [2:0] check_cmd(input logic [ADDR_W-1:0] addr,
                                             input logic [LEN_W-1:0]  len,
                                             input logic [2:0]        size,
                                             input logic [1:0]        burst);
        logic [2:0] code;
        logic       len_ok;
        len_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                 (len == LEN_W'(7)) || (len == LEN_W'(15));
        code = 3'd0;
        if (size > MAX_SIZE) begin
            code = 3'd1;
        end else if (burst == BURST_RSVD) begin
            code = 3'd2;
        end else if (burst == BURST_WRAP && !len_ok) begin
            code = 3'd3;
        end else if (burst == BURST_WRAP &&
                     (addr & (beat_bytes(size) - ADDR_W'(1))) != '0) begin
            code = 3'd4;
`ifdef AXI_4KB_CHECK_EN
        end else if (burst == BURST_INCR && crosses_4kb(addr, len, size)) begin
            code = 3'd5;
`endif
        end
        return code;
    endfunction

    // INCR realigns from the (possibly unaligned) current address, so beat 0 needs no special case.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] cur,
                                                    input logic [1:0]        burst,
                                                    input logic [2:0]        size,
                                                    input logic [ADDR_W-1:0] lower,
                                                    input logic [ADDR_W-1:0] span);
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] nxt;
        b = beat_bytes(size);
        case (burst)
            BURST_INCR: nxt = (cur & ~(b - ADDR_W'(1))) + b;
            BURST_WRAP: begin
                nxt = cur + b;
                if (nxt == lower + span) nxt = lower;
            end
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

    always_comb begin
        cmd_code  = check_cmd(cmd_addr, cmd_len, cmd_size, cmd_burst);
        cmd_span  = span_bytes(cmd_len, cmd_size);
        idx_next  = beat_idx + LEN_W'(1);
        addr_next = next_addr(beat_addr, burst_r, size_r, wrap_lower, wrap_span);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            beat_valid <= 1'b0;
            beat_addr  <= '0;
            beat_idx   <= '0;
            beat_last  <= 1'b0;
            beat_op    <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= 3'd0;
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_code != 3'd0) begin
                            state     <= ERR;
                            err_valid <= 1'b1;
                            err_code  <= cmd_code;
                        end else begin
                            state      <= ACTIVE;
                            beat_valid <= 1'b1;
                            beat_addr  <= cmd_addr;
                            beat_idx   <= '0;
                            beat_last  <= (cmd_len == '0);
                            beat_op    <= cmd_op;
                            len_r      <= cmd_len;
                            size_r     <= cmd_size;
                            burst_r    <= cmd_burst;
                            wrap_span  <= cmd_span;
                            wrap_lower <= cmd_addr & ~(cmd_span - ADDR_W'(1));
                        end
                    end
                end
                ACTIVE: begin
                    if (beat_ready) begin
                        if (beat_last) begin
                            state      <= IDLE;
                            cmd_ready  <= 1'b1;
                            beat_valid <= 1'b0;
                            beat_last  <= 1'b0;
                            if (burst_cnt != '1) burst_cnt <= burst_cnt + CNT_W'(1);
                        end else begin
                            beat_idx  <= idx_next;
                            beat_addr <= addr_next;
                            beat_last <= (idx_next == len_r);
                        end
                    end
                end
                ERR: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    err_valid <= 1'b0;
                    err_code  <= 3'd0;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
